// File: rtl/rv64_pkg.sv
// rv64_pkg: shared RV64 core constants.
//   XLEN / RAW    : datapath and register-address widths
//   ALU_*         : ALU control encoding (ADD=1 .. PASS_OP2=11)
//   WORD_W        : width of W-type ops before sign extension to XLEN
package rv64_pkg;
  localparam int XLEN   = 64;
  localparam int RAW    = 5;
  localparam int WORD_W = 32;

  localparam logic [3:0] ALU_ADD      = 4'd1;
  localparam logic [3:0] ALU_SUB      = 4'd2;
  localparam logic [3:0] ALU_SLL      = 4'd3;
  localparam logic [3:0] ALU_SLT      = 4'd4;
  localparam logic [3:0] ALU_SLTU     = 4'd5;
  localparam logic [3:0] ALU_XOR      = 4'd6;
  localparam logic [3:0] ALU_SRL      = 4'd7;
  localparam logic [3:0] ALU_SRA      = 4'd8;
  localparam logic [3:0] ALU_OR       = 4'd9;
  localparam logic [3:0] ALU_AND      = 4'd10;
  localparam logic [3:0] ALU_PASS_OP2 = 4'd11;
endpackage

// File: rtl/ex_wb_pipe_if.sv
// ex_wb_pipe_if: execute -> writeback bundle.
//   ALU side : alu_output, alu_valid, ex_rd, ex_word_op, ex_ready, flush
//   WB side  : wb_valid, wb_ready, wb_data, wb_rd, wb_we
//   Forward  : fwd_valid, fwd_rd, fwd_data
// slave  = the ex_wb_pipe stage; master = the surrounding core (ALU + WB).
interface ex_wb_pipe_if #(
  parameter int XLEN = rv64_pkg::XLEN,
  parameter int RAW  = rv64_pkg::RAW
);
  logic [XLEN-1:0] alu_output;
  logic            alu_valid;
  logic [RAW-1:0]  ex_rd;
  logic            ex_word_op;
  logic            ex_ready;
  logic            flush;
  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_data;
  logic [RAW-1:0]  wb_rd;
  logic            wb_we;
  logic            fwd_valid;
  logic [RAW-1:0]  fwd_rd;
  logic [XLEN-1:0] fwd_data;

  modport slave (
    input  alu_output, alu_valid, ex_rd, ex_word_op, flush, wb_ready,
    output ex_ready, wb_valid, wb_data, wb_rd, wb_we, fwd_valid, fwd_rd, fwd_data
  );
  modport master (
    output alu_output, alu_valid, ex_rd, ex_word_op, flush, wb_ready,
    input  ex_ready, wb_valid, wb_data, wb_rd, wb_we, fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry valid/ready skid buffer, strict FIFO.
//   clk, rst (sync, active high), flush (drop both entries)
//   in_valid/in_data/in_ready   : upstream; in_ready is a pure register output
//   out_valid/out_data/out_ready: downstream, driven from the main entry M
//   yng_valid/yng_data          : youngest valid entry (S if valid, else M)
// S only fills while M is held, so in_ready = !S.valid never depends on out_ready.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         yng_valid,
  output logic [W-1:0] yng_data
);
  logic         m_vld, s_vld;
  logic [W-1:0] m_dat, s_dat;
  logic         acc, drain;

  assign acc   = in_valid && !s_vld;
  assign drain = m_vld && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_dat <= '0;
      s_dat <= '0;
    end else if (flush) begin
      // flush wins over accept and drain; a same-cycle drain was still consumed
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (!m_vld || drain) begin
      if (s_vld) begin
        m_vld <= 1'b1;
        m_dat <= s_dat;
        s_vld <= 1'b0;    // acc is impossible while S is valid
      end else if (acc) begin
        m_vld <= 1'b1;
        m_dat <= in_data;
      end else begin
        m_vld <= 1'b0;
      end
    end else if (acc) begin
      s_vld <= 1'b1;
      s_dat <= in_data;
    end
  end

  assign in_ready  = !s_vld;
  assign out_valid = m_vld;
  assign out_data  = m_dat;
  assign yng_valid = m_vld || s_vld;
  assign yng_data  = s_vld ? s_dat : m_dat;
endmodule

// File: rtl/ex_wb_pipe.sv
// ex_wb_pipe: EX -> WB pipeline stage behind the ALU.
//   clk, rst (sync, active high)
//   bus (ex_wb_pipe_if.slave): ALU result in, writeback handshake out,
//   forwarding view of the newest buffered result.
// W-type results are sign-extended from bit 31 on capture. Results land in a
// 2-entry skid buffer with payload {rd, data}; wb_we masks x0 writes while
// wb_valid still reports the entry for retire accounting.
// Build option: EX_WB_FWD_EN enables the fwd_* mux; otherwise fwd_* are 0.
module ex_wb_pipe import rv64_pkg::*; #(
  parameter int XLEN = rv64_pkg::XLEN,
  parameter int RAW  = rv64_pkg::RAW
) (
  input logic         clk,
  input logic         rst,
  ex_wb_pipe_if.slave bus
);
  localparam int PW = RAW + XLEN;

  logic [XLEN-1:0] cap_data;
  logic [PW-1:0]   out_pl, yng_pl;
  logic            yng_valid;

  assign cap_data = bus.ex_word_op
                  ? {{(XLEN-WORD_W){bus.alu_output[WORD_W-1]}}, bus.alu_output[WORD_W-1:0]}
                  : bus.alu_output;

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.alu_valid),
    .in_data   ({bus.ex_rd, cap_data}),
    .in_ready  (bus.ex_ready),
    .out_valid (bus.wb_valid),
    .out_data  (out_pl),
    .out_ready (bus.wb_ready),
    .yng_valid (yng_valid),
    .yng_data  (yng_pl)
  );

  assign bus.wb_rd   = out_pl[PW-1 -: RAW];
  assign bus.wb_data = out_pl[XLEN-1:0];
  assign bus.wb_we   = bus.wb_valid && (bus.wb_rd != '0);

`ifdef EX_WB_FWD_EN
  // Consumers must not forward x0 or anything that is being flushed.
  assign bus.fwd_valid = yng_valid && !bus.flush && (yng_pl[PW-1 -: RAW] != '0);
  assign bus.fwd_rd    = yng_valid ? yng_pl[PW-1 -: RAW] : '0;
  assign bus.fwd_data  = yng_valid ? yng_pl[XLEN-1:0] : '0;
`else
  logic unused_fwd;
  assign unused_fwd    = ^{yng_valid, yng_pl};
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_rd    = '0;
  assign bus.fwd_data  = '0;
`endif
endmodule
